// File: rtl/hamming_serial_decoder.sv
// ---------------------------------------------------------------------------
// hamming_serial_decoder
//
// Serial Hamming decoder. One codeword bit is accepted per qualified cycle,
// lowest position first. When the last bit of a frame arrives, a registered
// capture stage computes the syndrome on the next enabled edge. That edge also
// corrects a single-bit error, registers the data word and flags, and pulses
// valid_out for one cycle. The receive FSM never waits for the capture stage,
// so frames may arrive back to back.
//
// Parameters:
//   R      number of Hamming parity bits (3..5); N = 2^R-1, K = N-R
//   CNT_W  width of the saturating corrected-error counter
//
// Optional feature (macro HAMMING_SECDED_EN):
//   defined   - frame is N+1 bits; the last bit is even overall parity, which
//               allows double errors to be detected (SECDED)
//   undefined - frame is N bits; double_err is tied to 0
//
// Ports:
//   clk           clock, rising edge
//   rst           synchronous reset, active-high
//   ena           global enable; when low all state holds
//   bit_in        serial codeword bit
//   bit_valid     qualifies bit_in
//   frame_sync    with bit_valid: bit_in is position 1 of a new frame
//   data_out      decoded data word (bit 0 = lowest non-power-of-two position)
//   syndrome_out  syndrome of the last completed frame
//   valid_out     one-cycle pulse when data_out/syndrome_out update
//   corrected     last frame held a correctable error
//   double_err    last frame held an uncorrectable error (SECDED only)
//   frame_abort   one-cycle pulse when a partial frame is discarded
//   err_count     saturating count of frames reported with corrected=1
// ---------------------------------------------------------------------------
module hamming_serial_decoder #(
  parameter int R     = 3,
  parameter int CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic                  bit_in,
  input  logic                  bit_valid,
  input  logic                  frame_sync,
  output logic [(2**R)-R-2:0]   data_out,
  output logic [R-1:0]          syndrome_out,
  output logic                  valid_out,
  output logic                  corrected,
  output logic                  double_err,
  output logic                  frame_abort,
  output logic [CNT_W-1:0]      err_count
);

  localparam int N = (2 ** R) - 1;
  localparam int K = N - R;
`ifdef HAMMING_SECDED_EN
  localparam int L = N + 1;
`else
  localparam int L = N;
`endif
  localparam int CW_W = $clog2(L);
  localparam logic [CW_W-1:0] LAST = CW_W'(L - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t          state, state_nxt;
  logic [CW_W-1:0] cnt, cnt_nxt;     // number of bits already held in SHIFT
  logic [L-1:0]    cw;               // cw[p-1] holds codeword position p
  logic            pend;             // a completed frame awaits capture

  logic            bit_we;
  logic [CW_W-1:0] wr_idx;
  logic            abort_c;
  logic            done_c;

  // Position of the idx-th data bit (positions that are not powers of two).
  function automatic int data_pos(int idx);
    int seen;
    int result;
    seen   = 0;
    result = 0;
    for (int p = 3; p <= N; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (seen == idx) result = p;
        seen++;
      end
    end
    return result;
  endfunction

  // Receive FSM: next state, write strobe and frame events.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    bit_we    = 1'b0;
    wr_idx    = '0;
    abort_c   = 1'b0;
    done_c    = 1'b0;
    if (bit_valid) begin
      bit_we = 1'b1;
      case (state)
        IDLE: begin
          cnt_nxt   = CW_W'(1);
          state_nxt = SHIFT;
        end
        SHIFT: begin
          if (frame_sync) begin
            // Resynchronise: drop the partial frame, restart at position 1.
            abort_c = 1'b1;
            cnt_nxt = CW_W'(1);
          end else begin
            wr_idx = cnt;
            if (cnt == LAST) begin
              cnt_nxt   = '0;
              state_nxt = IDLE;
              done_c    = 1'b1;
            end else begin
              cnt_nxt = cnt + 1'b1;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Decode of the held frame. cw is not overwritten before capture: a new
  // frame writes position 1 at the earliest on the capture edge itself.
  logic [R-1:0]   syn_c;
  logic           flip_c;
  logic           corr_c;
  logic [N-1:0]   fixed_c;
  logic [K-1:0]   data_c;
`ifdef HAMMING_SECDED_EN
  logic           par_c;
  logic           derr_c;
`endif

  always_comb begin
    syn_c = '0;
    for (int p = 1; p <= N; p++) begin
      if (cw[p-1]) syn_c = syn_c ^ R'(p);
    end
`ifdef HAMMING_SECDED_EN
    par_c  = ^cw;
    // Odd overall parity means one error; even parity with a nonzero
    // syndrome means two, which cannot be located.
    flip_c = (syn_c != '0) && par_c;
    corr_c = par_c;
    derr_c = (syn_c != '0) && !par_c;
`else
    flip_c = (syn_c != '0);
    corr_c = flip_c;
`endif
    fixed_c = cw[N-1:0];
    for (int p = 1; p <= N; p++) begin
      if (flip_c && (syn_c == R'(p))) fixed_c[p-1] = ~cw[p-1];
    end
    data_c = '0;
    for (int j = 0; j < K; j++) begin
      data_c[j] = fixed_c[data_pos(j) - 1];
    end
  end

  // NOTE: every register below is assigned with <= so all of them sample the
  // pre-edge values; in particular the capture reads cw before this edge's write.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      cw           <= '0;
      pend         <= 1'b0;
      data_out     <= '0;
      syndrome_out <= '0;
      valid_out    <= 1'b0;
      corrected    <= 1'b0;
      frame_abort  <= 1'b0;
      err_count    <= '0;
`ifdef HAMMING_SECDED_EN
      double_err   <= 1'b0;
`endif
    end else begin
      valid_out   <= 1'b0;
      frame_abort <= 1'b0;
      if (ena) begin
        state       <= state_nxt;
        cnt         <= cnt_nxt;
        frame_abort <= abort_c;
        pend        <= done_c;
        if (bit_we) cw[wr_idx] <= bit_in;
        if (pend) begin
          data_out     <= data_c;
          syndrome_out <= syn_c;
          corrected    <= corr_c;
          valid_out    <= 1'b1;
`ifdef HAMMING_SECDED_EN
          double_err   <= derr_c;
`endif
          if (corr_c && (err_count != {CNT_W{1'b1}})) err_count <= err_count + 1'b1;
        end
      end
    end
  end

`ifndef HAMMING_SECDED_EN
  assign double_err = 1'b0;
`endif

endmodule

// File: tb/tb_hamming_serial_decoder.sv
// ---------------------------------------------------------------------------
// tb_hamming_serial_decoder
//
// Self-checking bench for hamming_serial_decoder with R=3 and CNT_W=2.
// Expected results go into a scoreboard queue as each frame is driven. A
// monitor pops one entry per valid_out pulse and compares the pulse cycle and
// all outputs. Works with and without HAMMING_SECDED_EN.
// ---------------------------------------------------------------------------
module tb_hamming_serial_decoder;

  localparam int R     = 3;
  localparam int N     = 7;
  localparam int K     = 4;
  localparam int CNT_W = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef HAMMING_SECDED_EN
  localparam int L = N + 1;
`else
  localparam int L = N;
`endif
  // Data 4'b1011 encoded, positions 1..7 = 1,0,1,0,1,0,1; parity bit 0.
  localparam logic [L:1] CLEAN_F = L'(7'b1010101);

  logic             clk = 1'b0;
  logic             rst, ena, bit_in, bit_valid, frame_sync;
  logic [K-1:0]     data_out;
  logic [R-1:0]     syndrome_out;
  logic             valid_out, corrected, double_err, frame_abort;
  logic [CNT_W-1:0] err_count;

  hamming_serial_decoder #(.R(R), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .ena(ena), .bit_in(bit_in), .bit_valid(bit_valid),
    .frame_sync(frame_sync), .data_out(data_out), .syndrome_out(syndrome_out),
    .valid_out(valid_out), .corrected(corrected), .double_err(double_err),
    .frame_abort(frame_abort), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [K-1:0]     data;
    logic [R-1:0]     syn;
    logic             corr;
    logic             derr;
    logic [CNT_W-1:0] cnt;
    int               due;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   last_acc = 0;
  int   first_acc = 0;
  int   exp_cnt = 0;
  int   abort_seen = 0;
  int   abort_cyc = -1;
  bit   mon_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: outputs sampled on the falling edge.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (frame_abort) begin
        abort_seen++;
        abort_cyc = cyc;
      end
      if (valid_out) begin
        if (sbq.size() == 0) begin
          check("spurious_valid", valid_out, 1'b0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check("valid_cycle", cyc, e.due);
          check("data_out", data_out, e.data);
          check("syndrome_out", syndrome_out, e.syn);
          check("corrected", corrected, e.corr);
          check("double_err", double_err, e.derr);
          check("err_count", err_count, e.cnt);
        end
      end
      if (sbq.size() > 0 && cyc > sbq[0].due) begin
        check("valid_late", cyc, sbq[0].due);
        void'(sbq.pop_front());
      end
    end
  end

  task automatic send_bit(input logic b, input logic s);
    @(negedge clk);
    bit_in     = b;
    bit_valid  = 1'b1;
    frame_sync = s;
    last_acc   = cyc + 1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bit_valid  = 1'b0;
      frame_sync = 1'b0;
      bit_in     = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [L:1] f, input bit sync_first,
                            input int gap_after, input int gap_len);
    for (int i = 1; i <= L; i++) begin
      send_bit(f[i], (i == 1) && sync_first);
      if (i == 1) first_acc = last_acc;
      if (i == gap_after) idle(gap_len);
    end
  endtask

  task automatic expect_out(input logic [K-1:0] d, input logic [R-1:0] s,
                            input logic c, input logic de, input int extra);
    exp_t e;
    if (c && exp_cnt < CMAX) exp_cnt++;
    e.data = d;
    e.syn  = s;
    e.corr = c;
    e.derr = de;
    e.cnt  = CNT_W'(exp_cnt);
    e.due  = last_acc + 1 + extra;
    sbq.push_back(e);
  endtask

  function automatic logic [L:1] flip(input logic [L:1] f, input int p);
    f[p] = ~f[p];
    return f;
  endfunction

  // Independent encoder: data bits at non-power-of-two positions, even parity.
  function automatic logic [L:1] encode(input logic [K-1:0] d);
    logic [N:1] c;
    logic [L:1] f;
    logic       x;
    int         j;
    c = '0;
    j = 0;
    for (int p = 1; p <= N; p++) begin
      if ((p & (p - 1)) != 0) begin
        c[p] = d[j];
        j++;
      end
    end
    for (int b = 0; b < R; b++) begin
      x = 1'b0;
      for (int p = 1; p <= N; p++) if (((p >> b) & 1) == 1) x ^= c[p];
      c[1 << b] = x;
    end
    f = L'(c);
`ifdef HAMMING_SECDED_EN
    f[L] = ^c;
`endif
    return f;
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [K-1:0] rd;
    int           rp;

    rst = 1'b1; ena = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; frame_sync = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_data", data_out, 0);
    check("rst_syn", syndrome_out, 0);
    check("rst_valid", valid_out, 0);
    check("rst_corr", corrected, 0);
    check("rst_derr", double_err, 0);
    check("rst_abort", frame_abort, 0);
    check("rst_cnt", err_count, 0);
    mon_en = 1'b1;

    // Clean frame.
    send_frame(CLEAN_F, 1'b0, 0, 0);
    expect_out(4'b1011, 3'd0, 1'b0, 1'b0, 0);
    idle(3);

    // Single error at position 5.
    send_frame(flip(CLEAN_F, 5), 1'b0, 0, 0);
    expect_out(4'b1011, 3'd5, 1'b1, 1'b0, 0);
    idle(3);

    // Back to back, then a 3-cycle gap mid-frame.
    send_frame(CLEAN_F, 1'b0, 0, 0);
    expect_out(4'b1011, 3'd0, 1'b0, 1'b0, 0);
    send_frame(CLEAN_F, 1'b0, 0, 0);
    expect_out(4'b1011, 3'd0, 1'b0, 1'b0, 0);
    send_frame(CLEAN_F, 1'b0, 3, 3);
    expect_out(4'b1011, 3'd0, 1'b0, 1'b0, 0);
    idle(3);

    // Sync and abort: 4 bits of a frame, then a resynchronised full frame.
    check("abort_none_yet", abort_seen, 0);
    for (int i = 1; i <= 4; i++) send_bit(CLEAN_F[i], 1'b0);
    send_frame(CLEAN_F, 1'b1, 0, 0);
    expect_out(4'b1011, 3'd0, 1'b0, 1'b0, 0);
    idle(3);
    check("abort_count", abort_seen, 1);
    check("abort_cycle", abort_cyc, first_acc);

    // Enable low right after the last bit: capture deferred, bits ignored.
    send_frame(flip(CLEAN_F, 3), 1'b0, 0, 0);
    expect_out(4'b1011, 3'd3, 1'b1, 1'b0, 2);
    repeat (2) begin
      @(negedge clk);
      ena = 1'b0; bit_valid = 1'b1; bit_in = 1'b1; frame_sync = 1'b1;
    end
    @(negedge clk);
    ena = 1'b1; bit_valid = 1'b0; frame_sync = 1'b0;
    send_frame(CLEAN_F, 1'b0, 0, 0);
    expect_out(4'b1011, 3'd0, 1'b0, 1'b0, 0);
    idle(3);

    // Random single errors; err_count saturates at 3.
    for (int t = 0; t < 4; t++) begin
      rd = K'($urandom_range(0, 15));
      rp = $urandom_range(1, N);
      send_frame(flip(encode(rd), rp), 1'b0, 0, 0);
      expect_out(rd, R'(rp), 1'b1, 1'b0, 0);
    end
    idle(3);
    check("cnt_saturated", err_count, CMAX);

`ifdef HAMMING_SECDED_EN
    // Double error (positions 2 and 5) and parity-bit-only error.
    send_frame(flip(flip(CLEAN_F, 2), 5), 1'b0, 0, 0);
    expect_out(4'b1001, 3'd7, 1'b0, 1'b1, 0);
    send_frame(flip(CLEAN_F, L), 1'b0, 0, 0);
    expect_out(4'b1011, 3'd0, 1'b1, 1'b0, 0);
    idle(3);
`endif

    // Reset mid-frame: no valid_out, no abort, outputs cleared.
    for (int i = 1; i <= 3; i++) send_bit(CLEAN_F[i], 1'b0);
    @(negedge clk);
    rst = 1'b1; bit_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0;
    idle(L + 2);
    check("rst2_data", data_out, 0);
    check("rst2_syn", syndrome_out, 0);
    check("rst2_corr", corrected, 0);
    check("rst2_derr", double_err, 0);
    check("rst2_cnt", err_count, 0);
    check("rst2_abort_total", abort_seen, 1);
    send_frame(flip(CLEAN_F, 6), 1'b0, 0, 0);
    expect_out(4'b1011, 3'd6, 1'b1, 1'b0, 0);
    idle(5);
    check("sb_empty", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
